interfaz_salida_param: RTL and testbench

- Parametrised, registered successor to the elevator output interface.
- Owns the button-light state for N floors: cabin buttons, hall-up calls and hall-down calls.
- Drives the floor/direction display, a door-open blink strobe and an arrival chime pulse.
- Sits between the controller FSM (floor, direction, door, motion) and the panel/display drivers.

---
 rtl/ascensor_pkg.sv | 21 ++
 rtl/parpadeador.sv | 43 ++++
 rtl/interfaz_salida_param.sv | 95 +++++++++
 tb/tb_interfaz_salida_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ascensor_pkg.sv
// Shared elevator definitions: direction encodings and lamp-vector index helpers.
package ascensor_pkg;

   localparam logic [1:0] DIR_SUBE = 2'b11;
   localparam logic [1:0] DIR_BAJA = 2'b10;
   localparam logic [1:0] DIR_NADA = 2'b00;

   // Lamp layout: cabin [N-1:0], up calls from bit N (floors 0..N-2), down calls from bit 2N-1 (floors 1..N-1).
   function automatic int idx_cabina(input int p);
      return p;
   endfunction

   function automatic int idx_sube(input int n_pisos, input int p);
      return n_pisos + p;
   endfunction

   function automatic int idx_baja(input int n_pisos, input int p);
      return 2 * n_pisos - 2 + p;
   endfunction

endpackage

// File: rtl/parpadeador.sv
// Door-open blink strobe: held at 1 while disabled, toggles every T_PARPADEO enabled cycles.
module parpadeador #(
   parameter int T_PARPADEO = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic habilitar,
   output logic parpadeo
);

   localparam int CW = $clog2(T_PARPADEO);
   localparam logic [CW-1:0] CNT_FIN = CW'(T_PARPADEO - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          parpadeo_q, parpadeo_d;

   always_comb begin
      cnt_d      = cnt_q;
      parpadeo_d = parpadeo_q;
      if (!habilitar) begin
         cnt_d      = '0;
         parpadeo_d = 1'b1;
      end else if (cnt_q == CNT_FIN) begin
         cnt_d      = '0;
         parpadeo_d = ~parpadeo_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         parpadeo_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         parpadeo_q <= parpadeo_d;
      end
   end

   assign parpadeo = parpadeo_q;

endmodule

// File: rtl/interfaz_salida_param.sv
// Elevator output interface: button-lamp state, floor/direction display, blink strobe and arrival chime.
module interfaz_salida_param
   import ascensor_pkg::*;
#(
   parameter  int N_PISOS    = 4,
   parameter  int T_PARPADEO = 25000000,
   localparam int PW         = $clog2(N_PISOS),
   localparam int NL         = 3 * N_PISOS - 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NL-1:0] solicitudes,
   input  logic [PW-1:0] piso_actual,
   input  logic [1:0]    direccion,
   input  logic          en_movimiento,
   input  logic          puerta_abierta,
   output logic [NL-1:0] luces,
   output logic [PW-1:0] display_piso,
   output logic [1:0]    display_dir,
   output logic          parpadeo,
   output logic          campana
);

   localparam logic [PW:0] N_EXT = (PW + 1)'(N_PISOS);

   logic [NL-1:0] luces_q, luces_d;
   logic [PW-1:0] piso_q, piso_d;
   logic [1:0]    dir_q, dir_d;
   logic          campana_q, campana_d;
   logic          cerrada_q, cerrada_d;
   logic [NL-1:0] limpiar;
   logic          piso_valido;
   logic          en_servicio;

   always_comb begin
      piso_valido = ({1'b0, piso_actual} < N_EXT);
      en_servicio = puerta_abierta & ~en_movimiento & piso_valido;
      limpiar     = '0;
      for (int p = 0; p < N_PISOS; p++) begin
         if (en_servicio && piso_actual == PW'(p))
            limpiar[idx_cabina(p)] = 1'b1;
      end
      for (int p = 0; p < N_PISOS - 1; p++) begin
         if (en_servicio && piso_actual == PW'(p) && direccion != DIR_BAJA)
            limpiar[idx_sube(N_PISOS, p)] = 1'b1;
      end
      for (int p = 1; p < N_PISOS; p++) begin
         if (en_servicio && piso_actual == PW'(p) && direccion != DIR_SUBE)
            limpiar[idx_baja(N_PISOS, p)] = 1'b1;
      end
   end

   always_comb begin
      // Clear dominates a same-cycle press, so a request at the serviced floor never lights.
      luces_d = (luces_q | solicitudes) & ~limpiar;
      piso_d  = piso_valido ? piso_actual : piso_q;
      dir_d   = DIR_NADA;
      if ((en_movimiento || (|luces_q)) && direccion[1])
         dir_d = direccion;
      // cerrada_q resets to 0 so a door already open when reset releases never chimes.
      campana_d = puerta_abierta & cerrada_q & ~en_movimiento;
      cerrada_d = ~puerta_abierta;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         luces_q   <= '0;
         piso_q    <= '0;
         dir_q     <= DIR_NADA;
         campana_q <= 1'b0;
         cerrada_q <= 1'b0;
      end else begin
         luces_q   <= luces_d;
         piso_q    <= piso_d;
         dir_q     <= dir_d;
         campana_q <= campana_d;
         cerrada_q <= cerrada_d;
      end
   end

   parpadeador #(
      .T_PARPADEO(T_PARPADEO)
   ) u_parpadeador (
      .clk      (clk),
      .reset    (reset),
      .habilitar(puerta_abierta),
      .parpadeo (parpadeo)
   );

   assign luces        = luces_q;
   assign display_piso = piso_q;
   assign display_dir  = dir_q;
   assign campana      = campana_q;

endmodule

// File: tb/tb_interfaz_salida_param.sv
// Bench for interfaz_salida_param: directed vector table, blink sequence, randomized run against a model.
module tb_interfaz_salida_param;

   localparam int N  = 4;
   localparam int T  = 4;
   localparam int PW = 2;
   localparam int NL = 10;

   logic          clk;
   logic          reset;
   logic [NL-1:0] solicitudes;
   logic [PW-1:0] piso_actual;
   logic [1:0]    direccion;
   logic          en_movimiento;
   logic          puerta_abierta;
   logic [NL-1:0] luces;
   logic [PW-1:0] display_piso;
   logic [1:0]    display_dir;
   logic          parpadeo;
   logic          campana;

   interfaz_salida_param #(.N_PISOS(N), .T_PARPADEO(T)) dut (
      .clk           (clk),
      .reset         (reset),
      .solicitudes   (solicitudes),
      .piso_actual   (piso_actual),
      .direccion     (direccion),
      .en_movimiento (en_movimiento),
      .puerta_abierta(puerta_abierta),
      .luces         (luces),
      .display_piso  (display_piso),
      .display_dir   (display_dir),
      .parpadeo      (parpadeo),
      .campana       (campana)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nombre, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nombre, got, exp, $time);
   endtask

   // Reference model state: what each output must show after the edge just taken.
   logic [NL-1:0] m_luces;
   logic [PW-1:0] m_piso;
   logic [1:0]    m_dir;
   logic          m_parp, m_camp, m_last_door, m_base;
   int            m_open;

   task automatic model_edge();
      logic [NL-1:0] nxt;
      int p;
      if (reset) begin
         m_luces = '0; m_piso = '0; m_dir = '0; m_parp = 1'b0; m_camp = 1'b0;
         m_last_door = 1'b1; m_base = 1'b0; m_open = 0;
      end else begin
         p   = int'(piso_actual);
         nxt = m_luces | solicitudes;
         if (puerta_abierta && !en_movimiento && p < N) begin
            nxt[p] = 1'b0;
            if (p <= N - 2 && direccion != 2'b10) nxt[N + p] = 1'b0;
            if (p >= 1 && direccion != 2'b11) nxt[2*N - 2 + p] = 1'b0;
         end
         m_dir       = ((en_movimiento || m_luces != 0) && direccion[1]) ? direccion : 2'b00;
         m_piso      = (p < N) ? piso_actual : m_piso;
         m_camp      = puerta_abierta && !m_last_door && !en_movimiento;
         m_last_door = puerta_abierta;
         if (!puerta_abierta) begin
            m_open = 0; m_base = 1'b1; m_parp = 1'b1;
         end else begin
            m_open++;
            m_parp = m_base ^ 1'((m_open / T) % 2);
         end
         m_luces = nxt;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   typedef struct {
      logic          rst;
      logic [NL-1:0] sol;
      logic [PW-1:0] piso;
      logic [1:0]    dir;
      logic          mov;
      logic          door;
      logic [NL-1:0] e_luces;
      logic [PW-1:0] e_piso;
      logic [1:0]    e_dir;
      logic          e_parp;
      logic          e_camp;
   } vec_t;

   vec_t tabla[23];

   initial begin
      //           rst  sol      piso  dir    mov   door  luces    piso  dir    parp  camp
      tabla[0]  = '{1'b1, 10'h000, 2'd0, 2'b00, 1'b0, 1'b0, 10'h000, 2'd0, 2'b00, 1'b0, 1'b0};
      tabla[1]  = '{1'b0, 10'h005, 2'd0, 2'b00, 1'b0, 1'b0, 10'h005, 2'd0, 2'b00, 1'b1, 1'b0};
      tabla[2]  = '{1'b0, 10'h000, 2'd0, 2'b00, 1'b0, 1'b0, 10'h005, 2'd0, 2'b00, 1'b1, 1'b0};
      tabla[3]  = '{1'b0, 10'h000, 2'd0, 2'b11, 1'b0, 1'b0, 10'h005, 2'd0, 2'b11, 1'b1, 1'b0};
      tabla[4]  = '{1'b0, 10'h000, 2'd1, 2'b11, 1'b1, 1'b0, 10'h005, 2'd1, 2'b11, 1'b1, 1'b0};
      tabla[5]  = '{1'b0, 10'h000, 2'd2, 2'b11, 1'b0, 1'b1, 10'h001, 2'd2, 2'b11, 1'b1, 1'b1};
      tabla[6]  = '{1'b0, 10'h000, 2'd2, 2'b11, 1'b0, 1'b1, 10'h001, 2'd2, 2'b11, 1'b1, 1'b0};
      tabla[7]  = '{1'b0, 10'h000, 2'd2, 2'b11, 1'b0, 1'b0, 10'h001, 2'd2, 2'b11, 1'b1, 1'b0};
      tabla[8]  = '{1'b0, 10'h0A0, 2'd1, 2'b11, 1'b0, 1'b0, 10'h0A1, 2'd1, 2'b11, 1'b1, 1'b0};
      tabla[9]  = '{1'b0, 10'h000, 2'd1, 2'b11, 1'b0, 1'b1, 10'h081, 2'd1, 2'b11, 1'b1, 1'b1};
      tabla[10] = '{1'b0, 10'h000, 2'd1, 2'b00, 1'b0, 1'b1, 10'h001, 2'd1, 2'b00, 1'b1, 1'b0};
      tabla[11] = '{1'b0, 10'h002, 2'd1, 2'b00, 1'b0, 1'b1, 10'h001, 2'd1, 2'b00, 1'b1, 1'b0};
      tabla[12] = '{1'b0, 10'h000, 2'd1, 2'b00, 1'b0, 1'b1, 10'h001, 2'd1, 2'b00, 1'b0, 1'b0};
      tabla[13] = '{1'b0, 10'h000, 2'd3, 2'b00, 1'b0, 1'b0, 10'h001, 2'd3, 2'b00, 1'b1, 1'b0};
      tabla[14] = '{1'b0, 10'h002, 2'd3, 2'b00, 1'b0, 1'b0, 10'h003, 2'd3, 2'b00, 1'b1, 1'b0};
      tabla[15] = '{1'b0, 10'h3FF, 2'd3, 2'b00, 1'b0, 1'b0, 10'h3FF, 2'd3, 2'b00, 1'b1, 1'b0};
      tabla[16] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'b11, 1'b1, 1'b0};
      tabla[17] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'b11, 1'b1, 1'b0};
      tabla[18] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'b11, 1'b1, 1'b0};
      tabla[19] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'b11, 1'b0, 1'b0};
      tabla[20] = '{1'b1, 10'h000, 2'd3, 2'b11, 1'b1, 1'b1, 10'h000, 2'd0, 2'b00, 1'b0, 1'b0};
      tabla[21] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b0, 1'b1, 10'h000, 2'd3, 2'b00, 1'b0, 1'b0};
      tabla[22] = '{1'b0, 10'h000, 2'd3, 2'b11, 1'b0, 1'b1, 10'h000, 2'd3, 2'b00, 1'b0, 1'b0};

      reset = 1'b1; solicitudes = '0; piso_actual = '0; direccion = 2'b00;
      en_movimiento = 1'b0; puerta_abierta = 1'b0;
      m_luces = '0; m_piso = '0; m_dir = '0; m_parp = 1'b0; m_camp = 1'b0;
      m_last_door = 1'b1; m_base = 1'b0; m_open = 0;

      for (int i = 0; i < 23; i++) begin
         reset = tabla[i].rst; solicitudes = tabla[i].sol; piso_actual = tabla[i].piso;
         direccion = tabla[i].dir; en_movimiento = tabla[i].mov; puerta_abierta = tabla[i].door;
         step();
         chk($sformatf("vec%0d luces", i),   16'(luces),        16'(tabla[i].e_luces));
         chk($sformatf("vec%0d piso", i),    16'(display_piso), 16'(tabla[i].e_piso));
         chk($sformatf("vec%0d dir", i),     16'(display_dir),  16'(tabla[i].e_dir));
         chk($sformatf("vec%0d parp", i),    16'(parpadeo),     16'(tabla[i].e_parp));
         chk($sformatf("vec%0d campana", i), 16'(campana),      16'(tabla[i].e_camp));
      end

      // Blink sequence: door held open 20 cycles, then closed.
      reset = 1'b1; solicitudes = '0; piso_actual = 2'd0; direccion = 2'b00;
      en_movimiento = 1'b0; puerta_abierta = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("blink closed", 16'(parpadeo), 16'(1));
      puerta_abierta = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("blink open%0d", i), 16'(parpadeo), 16'((((i + 1) / 4) % 2) == 0));
         chk($sformatf("blink chime%0d", i), 16'(campana), 16'(i == 0));
      end
      puerta_abierta = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("blink after close%0d", i), 16'(parpadeo), 16'(1));
      end

      // Randomized traffic against the model.
      reset = 1'b1;
      step();
      for (int k = 0; k < 1500; k++) begin
         reset          = ($urandom_range(0, 199) == 0);
         solicitudes    = NL'($urandom & $urandom & $urandom);
         piso_actual    = PW'($urandom_range(0, N - 1));
         direccion      = 2'($urandom);
         en_movimiento  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) == 0) puerta_abierta = ~puerta_abierta;
         step();
         chk("rnd luces",   16'(luces),        16'(m_luces));
         chk("rnd piso",    16'(display_piso), 16'(m_piso));
         chk("rnd dir",     16'(display_dir),  16'(m_dir));
         chk("rnd parp",    16'(parpadeo),     16'(m_parp));
         chk("rnd campana", 16'(campana),      16'(m_camp));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
